dpi_stream_sequencer: RTL and testbench

Front-end controller for a bank of NUM_REGEX per-category regex matcher wrappers that share one character bus and one stream-state memory interface. It accepts a byte stream framed by sop/eop and tagged with a stream id. Per packet it drives the matcher bank's control sequence: state load (new or restored stream), restore gap, character streaming, drain, end-of-packet commit. It also holds a per-stream enable mask and reports the per-packet match vector.

---
 rtl/dpi_stream_sequencer_if.sv | 65 ++++++
 rtl/dpi_stream_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpi_stream_sequencer_if.sv
// ----------------------------------------------------------------------------
// dpi_stream_sequencer_if
//
// Bundles every non-clock/reset signal of dpi_stream_sequencer:
//   s_*        byte stream in (valid/ready, sop/eop framing, stream id)
//   cfg_*      enable-mask table write port
//   clr_seen   clears the stream-seen table
//   m_*        control/character bus to the matcher bank, m_fired back
//   res_*      per-packet match result strobe
//   err_sop    protocol error pulse (sop inside a packet)
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment (upstream source, config host, matcher bank)
// ----------------------------------------------------------------------------
interface dpi_stream_sequencer_if #(
    parameter int NUM_REGEX = 8,
    parameter int SID_W     = 6
);
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           s_data;
    logic                 s_sop;
    logic                 s_eop;
    logic [SID_W-1:0]     s_sid;

    logic                 cfg_we;
    logic [SID_W-1:0]     cfg_sid;
    logic [NUM_REGEX-1:0] cfg_mask;
    logic                 clr_seen;

    logic [SID_W-1:0]     m_stream_id;
    logic                 m_new_stream_id;
    logic                 m_load_state;
    logic [7:0]           m_char_in;
    logic                 m_char_in_vld;
    logic                 m_eop;
    logic [NUM_REGEX-1:0] m_enable;
    logic [NUM_REGEX-1:0] m_fired;

    logic                 res_valid;
    logic [SID_W-1:0]     res_sid;
    logic [NUM_REGEX-1:0] res_match;
    logic                 err_sop;

    modport slave (
        input  s_valid, s_data, s_sop, s_eop, s_sid,
        input  cfg_we, cfg_sid, cfg_mask, clr_seen,
        input  m_fired,
        output s_ready,
        output m_stream_id, m_new_stream_id, m_load_state,
        output m_char_in, m_char_in_vld, m_eop, m_enable,
        output res_valid, res_sid, res_match, err_sop
    );

    modport master (
        output s_valid, s_data, s_sop, s_eop, s_sid,
        output cfg_we, cfg_sid, cfg_mask, clr_seen,
        output m_fired,
        input  s_ready,
        input  m_stream_id, m_new_stream_id, m_load_state,
        input  m_char_in, m_char_in_vld, m_eop, m_enable,
        input  res_valid, res_sid, res_match, err_sop
    );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// ----------------------------------------------------------------------------
// dpi_stream_sequencer
//
// Front-end controller for a bank of NUM_REGEX regex matcher wrappers that
// share one character bus and one stream-state memory. For every packet it
// runs the sequence
//   IDLE -> LOAD -> GAP (LOAD_GAP-1 cycles) -> STREAM -> DRAIN (DRAIN cycles)
//   -> EOP -> IDLE
// and reports fired & enable for the finished packet.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    dpi_stream_sequencer_if.slave, carrying:
//            s_valid/s_ready/s_data/s_sop/s_eop/s_sid   byte stream in
//            cfg_we/cfg_sid/cfg_mask                    enable-mask writes
//            clr_seen                                   clear seen table
//            m_stream_id/m_new_stream_id/m_load_state   state load control
//            m_char_in/m_char_in_vld                    registered characters
//            m_eop/m_enable/m_fired                     commit, enables, flags
//            res_valid/res_sid/res_match                per-packet result
//            err_sop                                    sop inside a packet
//
// Cycle budget per packet of N bytes (no input stalls):
//   1 (IDLE) + 1 (LOAD) + (LOAD_GAP-1) + N (STREAM) + DRAIN + 1 (EOP)
// The sop beat is accepted LOAD_GAP cycles after the load strobe and shows
// on m_char_in one cycle later; m_eop follows the last character by DRAIN
// cycles (the DRAIN state starts on the cycle that last character shows).
// ----------------------------------------------------------------------------
module dpi_stream_sequencer #(
    parameter int NUM_REGEX = 8,
    parameter int SID_W     = 6,
    parameter int LOAD_GAP  = 2,
    parameter int DRAIN     = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    dpi_stream_sequencer_if.slave  bus
);

    localparam int NUM_SID = 1 << SID_W;

    // One down-counter serves both GAP and DRAIN; it is loaded with
    // (length-1) and the state exits on zero.
    localparam int CNT_MAX = (LOAD_GAP > DRAIN) ? LOAD_GAP : DRAIN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(LOAD_GAP - 2);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_EOP    = 3'd5;

    logic [2:0]           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [SID_W-1:0]     sid_q,      sid_d;
    logic [NUM_REGEX-1:0] enable_q,   enable_d;
    logic                 first_q,    first_d;
    logic [7:0]           char_q,     char_d;
    logic                 char_vld_q, char_vld_d;
    logic                 err_sop_q,  err_sop_d;
    logic [NUM_SID-1:0]   seen_q,     seen_d;
    logic [NUM_REGEX-1:0] mask_q [NUM_SID];
    logic [NUM_REGEX-1:0] mask_d [NUM_SID];

    logic                 s_ready_c;
    logic [NUM_REGEX-1:0] mask_sel;

    // A write to the sid being latched on this very cycle wins over the
    // stored entry, so the packet starts with the freshly written mask.
    assign mask_sel = (bus.cfg_we && (bus.cfg_sid == bus.s_sid)) ? bus.cfg_mask
                                                                 : mask_q[bus.s_sid];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sid_d      = sid_q;
        enable_d   = enable_q;
        first_d    = first_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        err_sop_d  = 1'b0;
        s_ready_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Orphan beats are swallowed; a sop beat is held on the bus
                // until STREAM so it becomes the first character.
                s_ready_c = ~bus.s_sop;
                if (bus.s_valid && bus.s_sop) begin
                    sid_d    = bus.s_sid;
                    enable_d = mask_sel;
                    state_d  = ST_LOAD;
                end
            end

            ST_LOAD: begin
                first_d = 1'b1;
                if (LOAD_GAP > 1) begin
                    cnt_d   = GAP_INIT;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_STREAM;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STREAM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STREAM: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    char_d     = bus.s_data;
                    char_vld_d = 1'b1;
                    first_d    = 1'b0;
                    // Only the first beat may carry sop; a later one is
                    // flagged but still forwarded as data.
                    err_sop_d  = bus.s_sop & ~first_q;
                    if (bus.s_eop) begin
                        cnt_d   = DRAIN_INIT;
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_EOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_EOP: begin
                enable_d = '0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Seen table: set at the end of LOAD, a same-cycle clear wins.
    always_comb begin
        seen_d = seen_q;
        if (state_q == ST_LOAD) begin
            seen_d[sid_q] = 1'b1;
        end
        if (bus.clr_seen) begin
            seen_d = '0;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (bus.cfg_we) begin
            mask_d[bus.cfg_sid] = bus.cfg_mask;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sid_q      <= '0;
            enable_q   <= '0;
            first_q    <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            err_sop_q  <= 1'b0;
            seen_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sid_q      <= sid_d;
            enable_q   <= enable_d;
            first_q    <= first_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            err_sop_q  <= err_sop_d;
            seen_q     <= seen_d;
        end
    end

    // NOTE: the mask table is built from flops and must come up all-zero
    // (every stream disabled until configured), so it is reset explicitly;
    // this also keeps it out of RAM inference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '{default: '0};
        end else begin
            mask_q <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Nothing is consumed while the block is held in reset.
    assign bus.s_ready         = s_ready_c & rst_n;

    assign bus.m_stream_id     = sid_q;
    assign bus.m_load_state    = (state_q == ST_LOAD);
    assign bus.m_new_stream_id = (state_q == ST_LOAD) & ~seen_q[sid_q];
    assign bus.m_char_in       = char_q;
    assign bus.m_char_in_vld   = char_vld_q;
    assign bus.m_eop           = (state_q == ST_EOP);
    assign bus.m_enable        = enable_q;

    // The result samples m_fired in the EOP cycle itself, once the last
    // character has cleared the matcher pipeline.
    assign bus.res_valid       = (state_q == ST_EOP);
    assign bus.res_sid         = (state_q == ST_EOP) ? sid_q : '0;
    assign bus.res_match       = (state_q == ST_EOP) ? (bus.m_fired & enable_q) : '0;
    assign bus.err_sop         = err_sop_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dpi_stream_sequencer
//
// Directed stimulus with hand-computed expectations. The stimulus side pushes
// expected load events, characters and results into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_dpi_stream_sequencer;

    localparam int NUM_REGEX = 8;
    localparam int SID_W     = 6;
    localparam int LOAD_GAP  = 2;
    localparam int DRAIN     = 3;

    typedef struct packed {
        logic [SID_W-1:0]     sid;
        logic                 new_s;
        logic [NUM_REGEX-1:0] en;
    } load_t;

    typedef struct packed {
        logic [SID_W-1:0]     sid;
        logic [NUM_REGEX-1:0] match;
    } res_t;

    logic clk;
    logic rst_n;

    dpi_stream_sequencer_if #(.NUM_REGEX(NUM_REGEX), .SID_W(SID_W)) bus ();

    dpi_stream_sequencer #(
        .NUM_REGEX (NUM_REGEX),
        .SID_W     (SID_W),
        .LOAD_GAP  (LOAD_GAP),
        .DRAIN     (DRAIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    load_t      exp_load_q [$];
    logic [7:0] exp_char_q [$];
    res_t       exp_res_q  [$];

    int                   load_cyc      = 0;
    int                   last_char_cyc = 0;
    bit                   first_pending = 1'b0;
    logic [NUM_REGEX-1:0] cur_en        = '0;
    int                   eop_count     = 0;
    int                   err_count     = 0;
    logic [7:0]           err_char      = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: DUT presented 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        load_t ld;
        res_t  rs;
        logic [7:0] ch;
        if (bus.m_load_state === 1'b1) begin
            if (exp_load_q.size() == 0) begin
                report_unexpected("load_state", 32'(bus.m_stream_id));
            end else begin
                ld = exp_load_q.pop_front();
                check("load_sid", 32'(bus.m_stream_id), 32'(ld.sid));
                check("new_stream_id", 32'(bus.m_new_stream_id), 32'(ld.new_s));
                check("load_enable", 32'(bus.m_enable), 32'(ld.en));
                cur_en        = ld.en;
                load_cyc      = cyc;
                first_pending = 1'b1;
            end
        end
        if (bus.m_char_in_vld === 1'b1) begin
            if (exp_char_q.size() == 0) begin
                report_unexpected("char_in_vld", 32'(bus.m_char_in));
            end else begin
                ch = exp_char_q.pop_front();
                check("char_in", 32'(bus.m_char_in), 32'(ch));
                check("char_enable", 32'(bus.m_enable), 32'(cur_en));
                if (first_pending) begin
                    // sop beat accepted LOAD_GAP cycles after the load strobe,
                    // then one cycle through the character register
                    check("first_char_latency", 32'(cyc - load_cyc), 32'(LOAD_GAP + 1));
                    first_pending = 1'b0;
                end
                last_char_cyc = cyc;
            end
        end
        if (bus.m_eop === 1'b1) begin
            eop_count++;
            check("drain_latency", 32'(cyc - last_char_cyc), 32'(DRAIN));
            check("eop_enable", 32'(bus.m_enable), 32'(cur_en));
        end
        if (bus.res_valid === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                report_unexpected("res_valid", 32'(bus.res_match));
            end else begin
                rs = exp_res_q.pop_front();
                check("res_with_eop", 32'(bus.m_eop), 32'd1);
                check("res_sid", 32'(bus.res_sid), 32'(rs.sid));
                check("res_match", 32'(bus.res_match), 32'(rs.match));
            end
        end
        if (bus.err_sop === 1'b1) begin
            err_count++;
            err_char = bus.m_char_in;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return at posedge + 1)
    // ------------------------------------------------------------------
    task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eop,
                              input logic [SID_W-1:0] sid, output int waited);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sop   = sop;
        bus.s_eop   = eop;
        bus.s_sid   = sid;
        waited      = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) break;
            waited++;
            if (waited > 40) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: s_ready low for %0d cycles (data 0x%0h)", waited, d);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sop   = 1'b0;
        bus.s_eop   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_load_q.size() != 0 || exp_char_q.size() != 0 || exp_res_q.size() != 0)
               && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL packet_timeout: loads %0d chars %0d results %0d still pending",
                     exp_load_q.size(), exp_char_q.size(), exp_res_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [SID_W-1:0] sid, input logic [NUM_REGEX-1:0] mask);
        bus.cfg_we   = 1'b1;
        bus.cfg_sid  = sid;
        bus.cfg_mask = mask;
        @(posedge clk);
        #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_clr_seen();
        bus.clr_seen = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_seen = 1'b0;
    endtask

    // One packet of len bytes; sop_at marks an extra (illegal) sop beat,
    // gap inserts idle cycles between beats, wt writes the mask for this sid
    // in the same cycle the sop is first presented.
    task automatic send_packet(input logic [SID_W-1:0] sid, input logic [7:0] data [8],
                               input int len, input int sop_at, input int gap, input bit wt,
                               input logic new_s, input logic [NUM_REGEX-1:0] en,
                               input logic [NUM_REGEX-1:0] fired,
                               input logic [NUM_REGEX-1:0] exp_match);
        int w;
        exp_load_q.push_back('{sid: sid, new_s: new_s, en: en});
        for (int i = 0; i < len; i++) exp_char_q.push_back(data[i]);
        exp_res_q.push_back('{sid: sid, match: exp_match});
        bus.m_fired = fired;
        if (wt) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_sid  = sid;
            bus.cfg_mask = en;
        end
        for (int i = 0; i < len; i++) begin
            drive_beat(data[i], (i == 0) || (i == sop_at), i == len - 1, sid, w);
            bus.cfg_we = 1'b0;
            if (gap > 0 && i < len - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_done();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] b [8];
        int w;
        int errs_before;
        int eops_before;

        rst_n        = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_sop    = 1'b0;
        bus.s_eop    = 1'b0;
        bus.s_sid    = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sid  = '0;
        bus.cfg_mask = '0;
        bus.clr_seen = 1'b0;
        bus.m_fired  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_load_state", 32'(bus.m_load_state), 32'd0);
        check("rst_char_vld", 32'(bus.m_char_in_vld), 32'd0);
        check("rst_eop", 32'(bus.m_eop), 32'd0);
        check("rst_enable", 32'(bus.m_enable), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_stream_id", 32'(bus.m_stream_id), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // New stream, fired F3 under mask 0F -> 03
        cfg_write(6'd5, 8'h0F);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd5, b, 4, -1, 0, 1'b0, 1'b1, 8'h0F, 8'hF3, 8'h03);

        // Same sid again -> already seen
        b = '{8'h55, 8'h66, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd5, b, 3, -1, 0, 1'b0, 1'b0, 8'h0F, 8'h00, 8'h00);

        // After clr_seen the sid is new again
        pulse_clr_seen();
        b = '{8'h88, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd5, b, 2, -1, 0, 1'b0, 1'b1, 8'h0F, 8'hFF, 8'h0F);

        // Unconfigured sid: mask 00, enable stays 0, no match
        b = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd7, b, 3, -1, 0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00);

        // Orphan beats in IDLE: each consumed at once, nothing forwarded
        drive_beat(8'hE1, 1'b0, 1'b0, 6'd3, w);
        check("orphan0_wait", 32'(w), 32'd0);
        drive_beat(8'hE2, 1'b0, 1'b0, 6'd3, w);
        check("orphan1_wait", 32'(w), 32'd0);
        drive_beat(8'hE3, 1'b0, 1'b1, 6'd3, w);
        check("orphan2_wait", 32'(w), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Single-byte sop+eop packet on the top sid, mask written through
        // in the sop-latch cycle
        b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd63, b, 1, -1, 0, 1'b1, 1'b1, 8'hA5, 8'hFF, 8'hA5);

        // Mid-packet sop on the third beat, 2-cycle input stalls
        errs_before = err_count;
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd5, b, 4, 2, 2, 1'b0, 1'b0, 8'h0F, 8'h0F, 8'h0F);
        check("err_sop_pulses", 32'(err_count - errs_before), 32'd1);
        check("err_sop_char", 32'(err_char), 32'h03);

        // Reset in the middle of STREAM
        cfg_write(6'd9, 8'h3C);
        exp_load_q.push_back('{sid: 6'd9, new_s: 1'b1, en: 8'h3C});
        exp_char_q.push_back(8'hB1);
        exp_char_q.push_back(8'hB2);
        bus.m_fired = 8'hFF;
        drive_beat(8'hB1, 1'b1, 1'b0, 6'd9, w);
        drive_beat(8'hB2, 1'b0, 1'b0, 6'd9, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_s_ready", 32'(bus.s_ready), 32'd0);
        check("abort_load_state", 32'(bus.m_load_state), 32'd0);
        check("abort_new_stream", 32'(bus.m_new_stream_id), 32'd0);
        check("abort_stream_id", 32'(bus.m_stream_id), 32'd0);
        check("abort_char_in", 32'(bus.m_char_in), 32'd0);
        check("abort_char_vld", 32'(bus.m_char_in_vld), 32'd0);
        check("abort_eop", 32'(bus.m_eop), 32'd0);
        check("abort_enable", 32'(bus.m_enable), 32'd0);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_res_sid", 32'(bus.res_sid), 32'd0);
        check("abort_res_match", 32'(bus.res_match), 32'd0);
        check("abort_err_sop", 32'(bus.err_sop), 32'd0);
        check("abort_chars_drained", 32'(exp_char_q.size()), 32'd0);
        exp_load_q.delete();
        exp_char_q.delete();
        exp_res_q.delete();
        eops_before = eop_count;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_eop", 32'(eop_count - eops_before), 32'd0);

        // Prior sid after reset: new again, mask cleared
        b = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(6'd9, b, 2, -1, 0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
